sd_split: RTL and testbench

Memory-side responder for the SD mapper's 32-bit SD port. Accepts one 32-bit read or write request at a time and services it as two 16-bit beats on a 16-bit-wide backing RAM with fixed read latency. Returns assembled read data to the mapper with a one-cycle valid pulse. Sits between the mapper's SD port and the physical 16-bit RAM.

---
 rtl/sd_split_pkg.sv | 15 +
 rtl/sd_split_if.sv | 10 +
 rtl/sd_split_rdpipe.sv | 21 ++
 rtl/sd_split.sv | 80 ++++++++
 tb/tb_sd_split.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/sd_split_pkg.sv
// sd_split_pkg: shared FSM state type, beat-select constants, read-latency limits and half-word helpers for sd_split
package sd_split_pkg;
  typedef enum logic [2:0] {IDLE, BEAT0, BEAT1, DRAIN, RESP} state_t;
  localparam logic BEAT_LO = 1'b0;
  localparam logic BEAT_HI = 1'b1;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;
  localparam int CNT_W = $clog2(RD_LAT_MAX + 1);
  function automatic int clamp_lat(int l);
    return l < RD_LAT_MIN ? RD_LAT_MIN : (l > RD_LAT_MAX ? RD_LAT_MAX : l);
  endfunction
  function automatic logic [15:0] half(logic [31:0] w, logic sel);
    return sel == BEAT_HI ? w[31:16] : w[15:0];
  endfunction
endpackage

// File: rtl/sd_split_if.sv
// sd_split_if: mapper SD port (sd_req/sd_ready/sd_addr/sd_we/sd_wdata/sd_rdata/sd_rvalid) plus 16-bit RAM port (ram_addr/ram_we/ram_wdata/ram_rdata); slave = sd_split, master = mapper+RAM side
interface sd_split_if #(parameter int SD_AW = 3);
  logic sd_req, sd_ready, sd_we, sd_rvalid, ram_we;
  logic [SD_AW-1:0] sd_addr;
  logic [31:0] sd_wdata, sd_rdata;
  logic [SD_AW:0] ram_addr;
  logic [15:0] ram_wdata, ram_rdata;
  modport slave (input sd_req, sd_addr, sd_we, sd_wdata, ram_rdata, output sd_ready, sd_rdata, sd_rvalid, ram_addr, ram_we, ram_wdata);
  modport master (output sd_req, sd_addr, sd_we, sd_wdata, ram_rdata, input sd_ready, sd_rdata, sd_rvalid, ram_addr, ram_we, ram_wdata);
endinterface

// File: rtl/sd_split_rdpipe.sv
// sd_split_rdpipe: RD_LAT-deep read-tag shift pipe (clk, reset sync clear, tag_vld/tag_sel in) strobing capture_lo/capture_hi when a beat's RAM data is valid
module sd_split_rdpipe import sd_split_pkg::*; #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic tag_vld,
  input  logic tag_sel,
  output logic capture_lo,
  output logic capture_hi
);
  logic [RD_LAT-1:0][1:0] pipe;
  always_ff @(posedge clk)
    if (reset) pipe <= '0;
    else begin
      pipe[0] <= {tag_vld, tag_sel};
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  assign capture_lo = pipe[RD_LAT-1][1] && pipe[RD_LAT-1][0] == BEAT_LO;
  assign capture_hi = pipe[RD_LAT-1][1] && pipe[RD_LAT-1][0] == BEAT_HI;
endmodule

// File: rtl/sd_split.sv
// sd_split: 32-bit SD request responder split into two 16-bit RAM beats (clk, reset, sd_split_if.slave sd); define SD_SPLIT_HI_FIRST_EN to issue the high half first
module sd_split import sd_split_pkg::*; #(
  parameter int SD_AW = 3,
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  sd_split_if.slave sd
);
  localparam int LAT = clamp_lat(RD_LAT);
`ifdef SD_SPLIT_HI_FIRST_EN
  localparam logic FIRST = BEAT_HI;
`else
  localparam logic FIRST = BEAT_LO;
`endif
  state_t state, state_n;
  logic [SD_AW-1:0] addr_q;
  logic we_q;
  logic [31:0] wdata_q;
  logic [CNT_W-1:0] cnt;
  logic [15:0] lo_q, hi_q, ram_wdata_q;
  logic [SD_AW:0] ram_addr_q;
  logic ram_we_q, accept, cap_lo, cap_hi;
  assign accept = sd.sd_req && sd.sd_ready;
  always_comb begin
    state_n = state == IDLE  ? (accept ? BEAT0 : IDLE) :
              state == BEAT0 ? BEAT1 :
              state == BEAT1 ? (we_q ? IDLE : DRAIN) :
              state == DRAIN ? (cnt == CNT_W'(1) ? RESP : DRAIN) : IDLE;
  end
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_n;
  // RAM-side outputs are registered one step ahead so each beat's address/data sits on the bus for the whole BEAT cycle and holds afterwards
  always_ff @(posedge clk)
    if (reset) begin
      addr_q <= '0;
      we_q <= 1'b0;
      wdata_q <= '0;
      cnt <= '0;
      lo_q <= '0;
      hi_q <= '0;
      ram_addr_q <= '0;
      ram_wdata_q <= '0;
      ram_we_q <= 1'b0;
    end else begin
      if (accept) begin
        addr_q <= sd.sd_addr;
        we_q <= sd.sd_we;
        wdata_q <= sd.sd_wdata;
        ram_addr_q <= {sd.sd_addr, FIRST};
        ram_wdata_q <= half(sd.sd_wdata, FIRST);
        ram_we_q <= sd.sd_we;
      end
      if (state == BEAT0) begin
        ram_addr_q <= {addr_q, ~FIRST};
        ram_wdata_q <= half(wdata_q, ~FIRST);
      end
      if (state == BEAT1) begin
        ram_we_q <= 1'b0;
        cnt <= CNT_W'(LAT);
      end
      if (state == DRAIN) cnt <= cnt - 1'b1;
      if (cap_lo) lo_q <= sd.ram_rdata;
      if (cap_hi) hi_q <= sd.ram_rdata;
    end
  sd_split_rdpipe #(.RD_LAT(LAT)) u_rdpipe (
    .clk(clk),
    .reset(reset),
    .tag_vld(!we_q && (state == BEAT0 || state == BEAT1)),
    .tag_sel(state == BEAT0 ? FIRST : ~FIRST),
    .capture_lo(cap_lo),
    .capture_hi(cap_hi)
  );
  assign sd.sd_ready = state == IDLE && !reset;
  assign sd.sd_rvalid = state == RESP && !reset;
  assign sd.sd_rdata = {hi_q, lo_q};
  assign sd.ram_addr = ram_addr_q;
  assign sd.ram_we = ram_we_q && !reset;
  assign sd.ram_wdata = ram_wdata_q;
endmodule

// File: tb/tb_sd_split.sv
// tb_sd_split: scoreboard bench for sd_split at RD_LAT=1 (u[0]) and RD_LAT=3 (u[1]) with behavioural 16-bit RAMs
module tb_sd_split;
`ifdef SD_SPLIT_HI_FIRST_EN
  localparam logic FIRST = 1'b1;
`else
  localparam logic FIRST = 1'b0;
`endif
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int vectors = 0, miscompares = 0;
  logic rst [2];
  logic req [2];
  logic we [2];
  logic [2:0] addr [2];
  logic [31:0] wdata [2];
  logic ready [2];
  logic rvalid [2];
  logic ram_we [2];
  logic [31:0] rdata [2];
  logic [3:0] ram_addr [2];
  logic [15:0] ram_wdata [2];
  typedef struct {int g; logic [31:0] data; int at;} rsp_t;
  typedef struct {int g; logic [3:0] a; logic [15:0] d; int at;} beat_t;
  rsp_t rq[$];
  beat_t bq[$];

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int L = g == 0 ? 1 : 3;
    logic [15:0] mem [16];
    logic [15:0] dl [L];
    sd_split_if #(.SD_AW(3)) bus ();
    sd_split #(.SD_AW(3), .RD_LAT(L)) dut (.clk(clk), .reset(rst[g]), .sd(bus));
    assign bus.sd_req = req[g];
    assign bus.sd_we = we[g];
    assign bus.sd_addr = addr[g];
    assign bus.sd_wdata = wdata[g];
    assign ready[g] = bus.sd_ready;
    assign rvalid[g] = bus.sd_rvalid;
    assign rdata[g] = bus.sd_rdata;
    assign ram_we[g] = bus.ram_we;
    assign ram_addr[g] = bus.ram_addr;
    assign ram_wdata[g] = bus.ram_wdata;
    always @(posedge clk) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      dl[0] <= mem[bus.ram_addr];
      for (int k = 1; k < L; k++) dl[k] <= dl[k-1];
    end
    assign bus.ram_rdata = dl[L-1];
  end

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    rsp_t r;
    beat_t b;
    for (int i = 0; i < 2; i++) begin
      if (rvalid[i] === 1'b1) begin
        if (rq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL stray_rvalid inst %0d: got pulse at cycle %0d, required none", i, cyc);
        end else begin
          r = rq.pop_front();
          chk("rsp_inst", i, r.g);
          chk("rdata", rdata[i], r.data);
          chk("rvalid_cycle", cyc, r.at);
        end
      end
      if (ram_we[i] === 1'b1) begin
        if (bq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL stray_ram_we inst %0d: got write addr %h at cycle %0d, required none", i, ram_addr[i], cyc);
        end else begin
          b = bq.pop_front();
          chk("beat_inst", i, b.g);
          chk("beat_addr", ram_addr[i], b.a);
          chk("beat_data", ram_wdata[i], b.d);
          chk("beat_cycle", cyc, b.at);
        end
      end
    end
  end

  task automatic do_req(int g, logic w, logic [2:0] a, logic [31:0] d, logic [31:0] rexp, bit hold, int abort);
    int t, lat;
    lat = g == 0 ? 1 : 3;
    req[g] = 1'b1;
    we[g] = w;
    addr[g] = a;
    wdata[g] = d;
    for (int n = 0; !ready[g]; n++) begin
      if (n == 40) begin
        chk("accept_timeout", 0, 1);
        req[g] = 1'b0;
        return;
      end
      @(negedge clk);
    end
    t = cyc;
    if (w) begin
      bq.push_back('{g: g, a: {a, FIRST}, d: FIRST ? d[31:16] : d[15:0], at: t + 1});
      bq.push_back('{g: g, a: {a, ~FIRST}, d: FIRST ? d[15:0] : d[31:16], at: t + 2});
    end else if (abort == 0) rq.push_back('{g: g, data: rexp, at: t + 3 + lat});
    @(negedge clk);
    if (hold) begin
      we[g] = 1'b1;
      addr[g] = a ^ 3'b101;
      wdata[g] = 32'hdeaddead;
    end else req[g] = 1'b0;
    while (!ready[g]) begin
      if (abort != 0 && cyc - t == abort) begin
        rst[g] = 1'b1;
        @(negedge clk);
        rst[g] = 1'b0;
        #1;
        chk("ready_after_abort", ready[g], 1);
        return;
      end
      if (cyc - t > 40) begin
        chk("busy_timeout", 0, 1);
        return;
      end
      @(negedge clk);
    end
    chk(w ? "wr_busy_cycles" : "rd_busy_cycles", cyc - t, w ? 3 : 4 + lat);
  endtask

  initial begin
    rst = '{1'b1, 1'b1};
    req = '{1'b0, 1'b0};
    we = '{1'b0, 1'b0};
    addr = '{3'd0, 3'd0};
    wdata = '{32'd0, 32'd0};
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", ready[i], 0);
      chk("rst_rvalid", rvalid[i], 0);
      chk("rst_ram_we", ram_we[i], 0);
      chk("rst_ram_addr", ram_addr[i], 0);
      chk("rst_ram_wdata", ram_wdata[i], 0);
      chk("rst_rdata", rdata[i], 0);
    end
    rst = '{1'b0, 1'b0};
    #1;
    chk("ready_after_rst0", ready[0], 1);
    chk("ready_after_rst1", ready[1], 1);
    do_req(0, 1'b1, 3'd2, 32'hcafebabe, 0, 0, 0);
    chk("mem0_4", u[0].mem[4], 16'hbabe);
    chk("mem0_5", u[0].mem[5], 16'hcafe);
    do_req(0, 1'b0, 3'd2, 0, 32'hcafebabe, 0, 0);
    do_req(1, 1'b1, 3'd2, 32'hcafebabe, 0, 0, 0);
    do_req(1, 1'b0, 3'd2, 0, 32'hcafebabe, 0, 0);
    do_req(0, 1'b1, 3'd0, 32'hfafafafa, 0, 1, 0);
    do_req(0, 1'b1, 3'd7, 32'hfafafafa, 0, 0, 0);
    chk("mem0_0", u[0].mem[0], 16'hfafa);
    chk("mem0_1", u[0].mem[1], 16'hfafa);
    chk("mem0_14", u[0].mem[14], 16'hfafa);
    chk("mem0_15", u[0].mem[15], 16'hfafa);
    do_req(0, 1'b0, 3'd7, 0, 32'hfafafafa, 0, 0);
    do_req(1, 1'b1, 3'd5, 32'h12345678, 0, 0, 0);
    do_req(1, 1'b0, 3'd5, 0, 0, 0, 4);
    do_req(1, 1'b0, 3'd5, 0, 32'h12345678, 0, 0);
    do_req(1, 1'b0, 3'd2, 0, 32'hcafebabe, 0, 0);
    do_req(0, 1'b1, 3'd3, 32'h0badf00d, 0, 0, 0);
    chk("mem0_6", u[0].mem[6], 16'hf00d);
    chk("mem0_7", u[0].mem[7], 16'h0bad);
    do_req(0, 1'b0, 3'd3, 0, 32'h0badf00d, 0, 0);
    repeat (10) @(negedge clk);
    chk("rsp_queue_drained", rq.size(), 0);
    chk("beat_queue_drained", bq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
